// File: rtl/axi_lite_master_if_if.sv
// Command-side and AXI4-Lite master signal bundle for axi_lite_master_if.
// The master modport is the bridge's view; the slave modport is the environment's.
interface axi_lite_master_if_if #(
  parameter int ADDR_WIDTH = 14
);
  // Command side
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_wstrb;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  // AXI4-Lite channels
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [31:0]           M_AXI_WDATA;
  logic [3:0]            M_AXI_WSTRB;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [31:0]           M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_master_if.sv
// Single-outstanding AXI4-Lite master: turns one command request into one
// AXI read or write and returns a one-cycle completion pulse.
//
// Handshakes: a transfer happens on a rising clock edge where VALID and READY
// are both high. Once raised, VALID holds with stable address/data until that
// edge; READY may be high without VALID. req_ready depends on state only.
module axi_lite_master_if #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                 M_AXI_ACLK,
  input  logic                 M_AXI_ARESETN,
  axi_lite_master_if_if.master bus,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [31:0]           r_wdata, w_wdata_nxt;
  logic [3:0]            r_wstrb, w_wstrb_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic                  r_wvalid, w_wvalid_nxt;
  logic                  r_arvalid, w_arvalid_nxt;
  logic                  r_resp_valid, w_resp_valid_nxt;
  logic [31:0]           r_resp_rdata, w_resp_rdata_nxt;
  logic                  r_resp_err, w_resp_err_nxt;

  // AW and W retire independently; each stays pending until its own READY.
  logic w_aw_pending;
  logic w_w_pending;
  logic w_unused_resp_lsb;

  assign w_aw_pending      = r_awvalid & ~bus.M_AXI_AWREADY;
  assign w_w_pending       = r_wvalid  & ~bus.M_AXI_WREADY;
  assign w_unused_resp_lsb = bus.M_AXI_BRESP[0] ^ bus.M_AXI_RRESP[0];

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wstrb      <= w_wstrb_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_wstrb_nxt      = r_wstrb;
    w_awvalid_nxt    = r_awvalid;
    w_wvalid_nxt     = r_wvalid;
    w_arvalid_nxt    = r_arvalid;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_addr_nxt  = bus.req_addr;
          w_wdata_nxt = bus.req_wdata;
          w_wstrb_nxt = bus.req_wstrb;
          if (bus.req_wen) begin
            w_state_nxt   = WADDR;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = RADDR;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      WADDR: begin
        w_awvalid_nxt = w_aw_pending;
        w_wvalid_nxt  = w_w_pending;
        if (!w_aw_pending && !w_w_pending) begin
          w_state_nxt = WRESP;
        end
      end
      WRESP: begin
        if (bus.M_AXI_BVALID) begin
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = '0;
          w_resp_err_nxt   = bus.M_AXI_BRESP[1];
          w_state_nxt      = IDLE;
        end
      end
      RADDR: begin
        if (bus.M_AXI_ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_state_nxt   = RDATA;
        end
      end
      RDATA: begin
        if (bus.M_AXI_RVALID) begin
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = bus.M_AXI_RDATA;
          w_resp_err_nxt   = bus.M_AXI_RRESP[1];
          w_state_nxt      = IDLE;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_arvalid_nxt = 1'b0;
      end
    endcase
  end

  // Every AXI-facing output is a register or a decode of the state register.
  assign bus.req_ready     = (r_state == IDLE);
  assign bus.M_AXI_AWADDR  = r_addr;
  assign bus.M_AXI_AWVALID = r_awvalid;
  assign bus.M_AXI_WDATA   = r_wdata;
  assign bus.M_AXI_WSTRB   = r_wstrb;
  assign bus.M_AXI_WVALID  = r_wvalid;
  assign bus.M_AXI_BREADY  = (r_state == WRESP);
  assign bus.M_AXI_ARADDR  = r_addr;
  assign bus.M_AXI_ARVALID = r_arvalid;
  assign bus.M_AXI_RREADY  = (r_state == RDATA);
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_rdata    = r_resp_rdata;
  assign bus.resp_err      = r_resp_err;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_axi_lite_master_if.sv
// Bench for axi_lite_master_if: directed vector table, random transfers against
// a latency/response model, plus reset-abort and ignored-response sequences.
module tb_axi_lite_master_if;
  localparam int AW = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  axi_lite_master_if_if #(.ADDR_WIDTH(AW)) bus ();

  axi_lite_master_if #(.ADDR_WIDTH(AW)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .bus           (bus),
    .o_dbg_state   (dbg_state)
  );

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    int            aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [31:0]   rdata;
    logic [1:0]    resp;
    int            exp_lat;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          hs_errs;
  logic [32:0] exp_q[$];
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [AW-1:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int aw, input int w, input int b,
                              input int ar, input int r, input logic [31:0] rdata, input logic [1:0] resp,
                              input int lat, input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.aw_dly = aw; v.w_dly = w; v.b_dly = b; v.ar_dly = ar; v.r_dly = r;
    v.rdata = rdata; v.resp = resp;
    v.exp_lat = lat; v.exp_rdata = erd; v.exp_err = eerr;
    return v;
  endfunction

  // Reference: 3-cycle base latency plus slave wait states; AW and W overlap.
  function automatic int model_lat(input vec_t v);
    if (v.wen) return 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly;
    return 3 + v.ar_dly + v.r_dly;
  endfunction

  task automatic clear_slave();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_RRESP   = 2'b00;
    bus.M_AXI_RDATA   = '0;
  endtask

  // Entered and left at a negedge; the resp_valid cycle of one call is the accept cycle of the next.
  task automatic do_txn(input vec_t v, input string tag);
    int  errs = 0;
    int  aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
    bit  aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
    bit  seen = 0;
    logic [32:0] er;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    clear_slave();
    bus.req_valid = 1'b1;
    bus.req_wen   = v.wen;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_wstrb = v.wstrb;
    chk($sformatf("%s_accept_ready", tag), bus.req_ready, 1);
    for (int c = 1; c <= v.exp_lat + 8 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'($urandom_range(0, 1));
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = $urandom;
        bus.req_wstrb = 4'($urandom);
      end
      if (bus.M_AXI_AWVALID !== (v.wen && !aw_d)) errs++;
      if (bus.M_AXI_WVALID !== (v.wen && !w_d)) errs++;
      if (bus.M_AXI_ARVALID !== (!v.wen && !ar_d)) errs++;
      if (bus.M_AXI_BREADY !== (v.wen && aw_d && w_d && !b_d)) errs++;
      if (bus.M_AXI_RREADY !== (!v.wen && ar_d && !r_d)) errs++;
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWADDR !== v.addr) errs++;
      if (bus.M_AXI_WVALID && (bus.M_AXI_WDATA !== v.wdata || bus.M_AXI_WSTRB !== v.wstrb)) errs++;
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARADDR !== v.addr) errs++;
      if (bus.req_ready !== (c == v.exp_lat)) errs++;
      if (bus.resp_valid === 1'b1) begin
        seen = 1;
        er = exp_q.pop_front();
        chk($sformatf("%s_latency", tag), c, v.exp_lat);
        chk($sformatf("%s_rdata", tag), bus.resp_rdata, er[31:0]);
        chk($sformatf("%s_err", tag), bus.resp_err, er[32]);
        m_rdata = er[31:0];
        m_err   = er[32];
        clear_slave();
      end else begin
        if (bus.resp_rdata !== m_rdata || bus.resp_err !== m_err) errs++;
        clear_slave();
        bus.M_AXI_RDATA = $urandom;
        // Response channels first, using handshake flags from earlier cycles.
        if (v.wen && aw_d && w_d && !b_d) begin
          bus.M_AXI_BVALID = (b_n >= v.b_dly);
          b_n++;
          bus.M_AXI_BRESP = bus.M_AXI_BVALID ? v.resp : 2'($urandom);
          if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) b_d = 1;
        end else if (!v.wen) begin
          bus.M_AXI_BVALID = 1'($urandom_range(0, 1));
          bus.M_AXI_BRESP  = 2'($urandom);
        end
        if (!v.wen && ar_d && !r_d) begin
          bus.M_AXI_RVALID = (r_n >= v.r_dly);
          r_n++;
          if (bus.M_AXI_RVALID) begin
            bus.M_AXI_RDATA = v.rdata;
            bus.M_AXI_RRESP = v.resp;
          end
          if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) r_d = 1;
        end else if (v.wen) begin
          bus.M_AXI_RVALID = 1'($urandom_range(0, 1));
          bus.M_AXI_RRESP  = 2'($urandom);
        end
        if (bus.M_AXI_AWVALID) begin
          bus.M_AXI_AWREADY = (aw_n >= v.aw_dly);
          aw_n++;
          if (bus.M_AXI_AWREADY) aw_d = 1;
        end
        if (bus.M_AXI_WVALID) begin
          bus.M_AXI_WREADY = (w_n >= v.w_dly);
          w_n++;
          if (bus.M_AXI_WREADY) w_d = 1;
        end
        if (bus.M_AXI_ARVALID) begin
          bus.M_AXI_ARREADY = (ar_n >= v.ar_dly);
          ar_n++;
          if (bus.M_AXI_ARREADY) ar_d = 1;
        end
      end
    end
    chk($sformatf("%s_resp_seen", tag), seen, 1);
    if (!seen) er = exp_q.pop_front();
    chk($sformatf("%s_protocol", tag), errs, 0);
  endtask

  // Idle with stray BVALID/RVALID: nothing may be acknowledged or completed.
  task automatic idle(input int n, input string tag);
    int errs = 0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      clear_slave();
      bus.M_AXI_BVALID = 1'($urandom_range(0, 1));
      bus.M_AXI_BRESP  = 2'($urandom);
      bus.M_AXI_RVALID = 1'($urandom_range(0, 1));
      bus.M_AXI_RRESP  = 2'($urandom);
      bus.M_AXI_RDATA  = $urandom;
      @(negedge clk);
      if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
           bus.M_AXI_BREADY, bus.M_AXI_RREADY, bus.resp_valid} !== 6'b0) errs++;
      if (bus.req_ready !== 1'b1) errs++;
      if (bus.resp_rdata !== m_rdata || bus.resp_err !== m_err) errs++;
    end
    clear_slave();
    chk(tag, errs, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0] = mk(1'b1, 14'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0,        2'b00, 3, 32'h0,        1'b0);
    tbl[1] = mk(1'b1, 14'h0010, 32'hCAFEF00D, 4'h3, 4, 0, 0, 0, 0, 32'h0,        2'b00, 7, 32'h0,        1'b0);
    tbl[2] = mk(1'b1, 14'h0044, 32'h0BADF00D, 4'hC, 0, 3, 2, 0, 0, 32'h0,        2'b10, 8, 32'h0,        1'b1);
    tbl[3] = mk(1'b0, 14'h0020, 32'h0,        4'h0, 0, 0, 0, 0, 2, 32'h12345678, 2'b00, 5, 32'h12345678, 1'b0);
    tbl[4] = mk(1'b0, 14'h3FFC, 32'h0,        4'h0, 0, 0, 0, 3, 0, 32'hFFFFFFFF, 2'b10, 6, 32'hFFFFFFFF, 1'b1);
    tbl[5] = mk(1'b1, 14'h2000, 32'h00000001, 4'h1, 2, 2, 0, 0, 0, 32'h0,        2'b11, 5, 32'h0,        1'b1);
    tbl[6] = mk(1'b1, 14'h0008, 32'h87654321, 4'hF, 1, 0, 1, 0, 0, 32'h0,        2'b01, 5, 32'h0,        1'b0);
    tbl[7] = mk(1'b0, 14'h0004, 32'h0,        4'h0, 0, 0, 0, 1, 1, 32'hA5A5A5A5, 2'b01, 5, 32'hA5A5A5A5, 1'b0);

    // Clock/reset
    clear_slave();
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID,
                          bus.M_AXI_RREADY, bus.resp_valid, bus.resp_err}, 0);
    chk("reset_rdata", bus.resp_rdata, 0);
    chk("reset_addr", {bus.M_AXI_AWADDR, bus.M_AXI_ARADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB}, 0);
    chk("reset_state_idle", dbg_state, 0);
    chk("reset_req_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    idle(4, "idle_stray_resp");

    // Directed table, issued back to back
    for (int i = 0; i < 8; i++) do_txn(tbl[i], $sformatf("vec%0d", i));
    idle(2, "idle_after_table");

    // Reset while waiting in WRESP: abort with no completion
    clear_slave();
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_addr = 14'h0100;
    bus.req_wdata = 32'h55AA55AA; bus.req_wstrb = 4'hF;
    chk("abort_accept_ready", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.M_AXI_AWREADY = 1'b1; bus.M_AXI_WREADY = 1'b1;
    @(negedge clk);
    bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
    chk("abort_bready_before", bus.M_AXI_BREADY, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_async_outputs", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID,
                                bus.M_AXI_RREADY, bus.resp_valid, bus.resp_err}, 0);
    chk("abort_async_rdata", bus.resp_rdata, 0);
    hs_errs = 0;
    bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = 2'b10;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) hs_errs++;
    end
    clear_slave();
    #1 rst_n = 1'b1;
    @(negedge clk);
    if (bus.resp_valid !== 1'b0) hs_errs++;
    chk("abort_no_resp_pulse", hs_errs, 0);
    m_rdata = '0;
    m_err   = 1'b0;
    do_txn(mk(1'b0, 14'h0030, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h600DCAFE, 2'b00, 3, 32'h600DCAFE, 1'b0),
           "post_reset_read");

    // Random transfers against the reference model
    for (int i = 0; i < 40; i++) begin
      v = mk(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 4'($urandom),
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
             $urandom_range(0, 4), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom, 2'($urandom), 0, 32'h0, 1'b0);
      v.exp_lat   = model_lat(v);
      v.exp_rdata = v.wen ? 32'h0 : v.rdata;
      v.exp_err   = v.resp[1];
      do_txn(v, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2), $sformatf("rnd%0d_gap", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_if.md
AXI_LITE_MASTER_IF -- requirements
Module: axi_lite_master_if

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, byte-address width of the AXI channels.
REQ-002 SHALL have port M_AXI_ACLK, input, 1, the single clock for all logic.
REQ-003 SHALL have port M_AXI_ARESETN, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, command request.
REQ-005 SHALL have port req_ready, output, 1, command accepted this cycle when req_valid is also high.
REQ-006 SHALL have port req_wen, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr, input, ADDR_WIDTH, byte address.
REQ-008 SHALL have port req_wdata, input, 32, write data.
REQ-009 SHALL have port req_wstrb, input, 4, byte strobes.
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32, read data (0 for writes).
REQ-012 SHALL have port resp_err, output, 1, BRESP/RRESP[1] of the completed transfer.
REQ-013 SHALL have AXI-Lite master ports: M_AXI_AWADDR[ADDR_WIDTH], AWVALID (out), AWREADY (in), WDATA[32], WSTRB[4], WVALID (out), WREADY (in), BRESP[2], BVALID (in), BREADY (out), ARADDR[ADDR_WIDTH], ARVALID (out), ARREADY (in), RDATA[32], RRESP[2], RVALID (in), RREADY (out).

Function
REQ-014 SHALL implement an FSM with states IDLE, WADDR (AW/W pending), WRESP, RADDR, RDATA.
REQ-015 SHALL assert req_ready only in IDLE; it SHALL be combinational on state only, not on req_valid.
REQ-016 On req_valid&req_ready, SHALL register addr/wdata/wstrb/wen; AXI outputs SHALL be driven from registers only.
REQ-017 Write accept: IDLE->WADDR; AWVALID and WVALID SHALL rise in the following cycle.
REQ-018 AWVALID SHALL clear on the cycle after AWREADY is sampled high; WVALID SHALL clear independently on the cycle after WREADY is sampled high; AW and W may complete in either order or in the same cycle.
REQ-019 After both AW and W are done, FSM SHALL enter WRESP with BREADY=1; BREADY SHALL be 0 in all other states.
REQ-020 In WRESP, on BVALID: resp_valid=1 for one cycle in the next cycle, resp_err=BRESP[1], resp_rdata=0, FSM->IDLE.
REQ-021 Read accept: IDLE->RADDR; ARVALID SHALL rise next cycle and be held until ARREADY is sampled high, then FSM->RDATA.
REQ-022 In RDATA, RREADY=1; on RVALID: capture RDATA into resp_rdata, resp_err=RRESP[1], resp_valid pulse next cycle, FSM->IDLE.
REQ-023 Once asserted, a VALID SHALL NOT drop and its address/data SHALL NOT change until the matching READY; AXI-stable rule.
REQ-024 Minimum latency: write = 3 cycles accept-to-resp_valid with zero-wait slave; read = 3 cycles.
REQ-025 resp_rdata and resp_err SHALL hold their value until the next completion.
REQ-026 A new request SHALL be acceptable in the cycle resp_valid is high (FSM already IDLE).
REQ-027 BVALID/RVALID arriving outside WRESP/RDATA SHALL be ignored (not acknowledged).
REQ-028 The 0xFFFFFFFF contention value returned by the slave SHALL be passed through unchanged as ordinary data.

Reset
REQ-029 While M_AXI_ARESETN=0: FSM=IDLE, all VALID/READY outputs=0, resp_valid=0, resp_rdata=0, resp_err=0, address/data registers=0.
REQ-030 Reset asserted mid-transfer SHALL abort immediately without a resp_valid pulse; the first request after deassertion SHALL be accepted in the first IDLE cycle.

Verification
REQ-031 Write addr 0x0010, data 0xDEADBEEF, wstrb 0xF, zero-wait slave -> AW/W each one cycle, BREADY, resp_valid at cycle 3, resp_err=0.
REQ-032 Write with AWREADY delayed 4 cycles and WREADY immediate -> WVALID clears first, AWVALID held with stable 0x0010, single resp_valid after BVALID.
REQ-033 Read addr 0x0020, RDATA 0x12345678 after 2 wait cycles, RRESP=00 -> resp_rdata=0x12345678, resp_err=0, one pulse.
REQ-034 Read with RRESP=10 and RDATA 0xFFFFFFFF -> resp_err=1, resp_rdata=0xFFFFFFFF.
REQ-035 Reset asserted while in WRESP -> all outputs 0 asynchronously, no resp_valid; read issued post-reset completes normally.
REQ-036 Back-to-back: new read presented during write's resp_valid cycle -> accepted that cycle, ARVALID next cycle.
